// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, RV32I load/store funct3 codes and the LSU state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} lsu_state_t;

  // Transfer size is carried in the low two funct3 bits for both loads and stores.
  function automatic logic [2:0] hsize_of(input logic [2:0] funct3);
    return {1'b0, funct3[1:0]};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane handling: request legality, store-data replication,
// and load-lane extraction with sign/zero extension.
module lsu_lane_align
  import ahb_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic        illegal,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    illegal = 1'b0;
    if (req_we) begin
      if (req_funct3 > F3_W) illegal = 1'b1;
    end else if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
      illegal = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr_lo[0]) illegal = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr_lo != 2'b00) illegal = 1'b1;
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   st_data = {4{req_wdata[7:0]}};
      2'b01:   st_data = {2{req_wdata[15:0]}};
      default: st_data = req_wdata;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'b00:   ld_byte = rdata[7:0];
      2'b01:   ld_byte = rdata[15:8];
      2'b10:   ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3[1:0])
      2'b00:   ld_data = ld_funct3[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = ld_funct3[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ahb_master.sv
// Load/store unit: one request -> one single AHB-Lite transfer, load writeback to x1..x31.
//   state | meaning
//   IDLE  | ready for a request; illegal requests skip the bus
//   ADDR  | NONSEQ address phase, held until HREADY
//   DATA  | data phase: waits, two-cycle ERROR, or completion
//   RESP  | one-cycle retire: done/err/misaligned and reg_write pulse
module lsu_ahb_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  output logic              done,
  output logic              err,
  output logic              misaligned,
  output logic              reg_write,
  output logic [4:0]        rd_sel,
  output logic [DATA_W-1:0] wb_data
);

  lsu_state_t        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        addr_lo_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] st_data_q;
  logic              err_pend;

  logic              illegal;
  logic [DATA_W-1:0] st_data;
  logic [DATA_W-1:0] ld_data;

  lsu_lane_align u_align (
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr_lo (req_addr[1:0]),
    .req_wdata   (req_wdata),
    .illegal     (illegal),
    .st_data     (st_data),
    .ld_funct3   (f3_q),
    .ld_addr_lo  (addr_lo_q),
    .rdata       (HRDATA),
    .ld_data     (ld_data)
  );

  assign req_ready = (state == IDLE);
  assign HBURST    = HBURST_SINGLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_lo_q  <= 2'b00;
      rd_q       <= 5'd0;
      st_data_q  <= '0;
      err_pend   <= 1'b0;
      HADDR      <= '0;
      HTRANS     <= HTRANS_IDLE;
      HWRITE     <= 1'b0;
      HSIZE      <= HSIZE_BYTE;
      HWDATA     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      misaligned <= 1'b0;
      reg_write  <= 1'b0;
      rd_sel     <= 5'd0;
      wb_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          err        <= 1'b0;
          misaligned <= 1'b0;
          reg_write  <= 1'b0;
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            rd_q      <= req_rd;
            st_data_q <= st_data;
            err_pend  <= 1'b0;
            if (illegal) begin
              // Rejected without touching the bus; retires on the next cycle.
              state      <= RESP;
              done       <= 1'b1;
              err        <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state  <= ADDR;
              HTRANS <= HTRANS_NONSEQ;
              HADDR  <= req_addr;
              HWRITE <= req_we;
              HSIZE  <= hsize_of(req_funct3);
            end
          end
        end
        ADDR: begin
          if (HREADY) begin
            state  <= DATA;
            HTRANS <= HTRANS_IDLE;
            if (we_q) HWDATA <= st_data_q;
          end
        end
        DATA: begin
          if (HREADY) begin
            state    <= RESP;
            done     <= 1'b1;
            HWDATA   <= '0;
            err_pend <= 1'b0;
            if (HRESP || err_pend) begin
              err <= 1'b1;
            end else if (!we_q && rd_q != 5'd0) begin
              reg_write <= 1'b1;
              rd_sel    <= rd_q;
              wb_data   <= ld_data;
            end
          end else if (HRESP) begin
            err_pend <= 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          done       <= 1'b0;
          err        <= 1'b0;
          misaligned <= 1'b0;
          reg_write  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ahb_master.sv
// Directed + randomized bench for lsu_ahb_master with a rule-level reference model.
module tb_lsu_ahb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        done;
  logic        err;
  logic        misaligned;
  logic        reg_write;
  logic [4:0]  rd_sel;
  logic [31:0] wb_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .done(done), .err(err), .misaligned(misaligned),
    .reg_write(reg_write), .rd_sel(rd_sel), .wb_data(wb_data)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: legality, store lane replication, load extraction.
  function automatic bit model_illegal(input bit we, input int f3, input int unsigned addr);
    int sz = f3 % 4;
    if (we && f3 > 2) return 1;
    if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1;
    if (sz == 1 && addr % 2 != 0) return 1;
    if (sz == 2 && addr % 4 != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_store(input int f3, input logic [31:0] wd);
    int sz = f3 % 4;
    if (sz == 0) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input int f3, input int unsigned addr, input logic [31:0] rd);
    int sz = f3 % 4;
    bit unsigned_ld = (f3 >= 4);
    logic [31:0] v;
    if (sz == 0) begin
      v = (rd >> ((addr % 4) * 8)) & 32'hFF;
      if (!unsigned_ld && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (rd >> (((addr % 4) / 2) * 16)) & 32'hFFFF;
      if (!unsigned_ld && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Issues one request and plays the AHB slave for it, checking each phase.
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                         input int aw, input int dw, input bit berr);
    bit ill = model_illegal(we, int'(f3), addr);
    bit exp_rw = !ill && !we && !berr && (rd != 0);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    HREADY = 1'b1; HRESP = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ill) begin
      check("ill_htrans", {30'd0, HTRANS}, 32'd0);
      check("ill_done", {31'd0, done}, 32'd1);
      check("ill_err", {31'd0, err}, 32'd1);
      check("ill_misaligned", {31'd0, misaligned}, 32'd1);
      check("ill_reg_write", {31'd0, reg_write}, 32'd0);
      @(posedge clk); #1;
      check("ill_htrans_after", {30'd0, HTRANS}, 32'd0);
      check("ill_done_clear", {31'd0, done}, 32'd0);
      check("ill_ready_after", {31'd0, req_ready}, 32'd1);
      return;
    end
    check("addr_htrans", {30'd0, HTRANS}, 32'd2);
    check("addr_haddr", HADDR, addr);
    check("addr_hwrite", {31'd0, HWRITE}, {31'd0, we});
    check("addr_hsize", {29'd0, HSIZE}, f3 % 4);
    check("addr_hburst", {29'd0, HBURST}, 32'd0);
    check("addr_ready_low", {31'd0, req_ready}, 32'd0);
    for (int i = 0; i < aw; i++) begin
      @(negedge clk); HREADY = 1'b0;
      @(posedge clk); #1;
      check("addr_wait_htrans", {30'd0, HTRANS}, 32'd2);
      check("addr_wait_haddr", HADDR, addr);
    end
    @(negedge clk); HREADY = 1'b1;
    @(posedge clk); #1;
    check("data_htrans", {30'd0, HTRANS}, 32'd0);
    if (we) check("data_hwdata", HWDATA, model_store(int'(f3), wd));
    for (int i = 0; i < dw; i++) begin
      @(negedge clk); HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
      @(posedge clk); #1;
      check("data_wait_done", {31'd0, done}, 32'd0);
      if (we) check("data_wait_hwdata", HWDATA, model_store(int'(f3), wd));
    end
    @(negedge clk);
    if (berr) begin
      HREADY = 1'b0; HRESP = 1'b1;
      @(posedge clk); #1;
      check("err_first_done", {31'd0, done}, 32'd0);
      @(negedge clk); HREADY = 1'b1;
    end else begin
      HREADY = 1'b1; HRDATA = rdata;
    end
    @(posedge clk); #1;
    check("resp_done", {31'd0, done}, 32'd1);
    check("resp_err", {31'd0, err}, {31'd0, berr});
    check("resp_misaligned", {31'd0, misaligned}, 32'd0);
    check("resp_reg_write", {31'd0, reg_write}, {31'd0, exp_rw});
    check("resp_ready_low", {31'd0, req_ready}, 32'd0);
    if (exp_rw) begin
      check("resp_rd_sel", {27'd0, rd_sel}, {27'd0, rd});
      check("resp_wb_data", wb_data, model_load(int'(f3), addr, rdata));
    end
    @(negedge clk); HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    @(posedge clk); #1;
    check("post_done", {31'd0, done}, 32'd0);
    check("post_reg_write", {31'd0, reg_write}, 32'd0);
    check("post_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    #23;
    check("rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    check("rst_hsize", {29'd0, HSIZE}, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check("rst_reg_write", {31'd0, reg_write}, 32'd0);
    check("rst_rd_sel", {27'd0, rd_sel}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    // Directed cases
    run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_req(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd3, 32'h8011_2233, 0, 2, 1'b0);
    run_req(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd3, 32'h8011_2233, 0, 2, 1'b0);
    run_req(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 5'd0, 32'h0, 0, 0, 1'b0);
    run_req(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd4, 32'h0, 0, 0, 1'b0);
    run_req(1'b0, 3'b001, 32'h0000_0040, 32'h0, 5'd7, 32'h1234_5678, 0, 0, 1'b1);
    run_req(1'b0, 3'b010, 32'h0000_0044, 32'h0, 5'd0, 32'h5555_AAAA, 1, 0, 1'b0);
    run_req(1'b1, 3'b000, 32'h0000_0081, 32'h1234_56C3, 5'd1, 32'h0, 2, 1, 1'b0);
    run_req(1'b1, 3'b011, 32'h0000_0080, 32'h0, 5'd1, 32'h0, 0, 0, 1'b0);
    run_req(1'b0, 3'b101, 32'h0000_0086, 32'h0, 5'd31, 32'hF00D_8001, 0, 0, 1'b0);

    // Randomized requests
    for (int n = 0; n < 60; n++) begin
      bit          r_we   = 1'($urandom_range(0, 1));
      logic [2:0]  r_f3   = 3'($urandom_range(0, 7));
      logic [31:0] r_addr = $urandom;
      logic [4:0]  r_rd   = 5'($urandom_range(0, 31));
      // Bias toward legal requests so most of them reach the bus.
      if ($urandom_range(0, 3) != 0) begin
        r_f3 = r_we ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
        if (r_f3[1:0] == 2'b01) r_addr[0] = 1'b0;
        if (r_f3[1:0] == 2'b10) r_addr[1:0] = 2'b00;
      end
      run_req(r_we, r_f3, r_addr, $urandom, r_rd, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    // Reset during address-phase wait abandons the transfer
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300; req_rd = 5'd9;
    HREADY = 1'b0; HRESP = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmid_htrans_ns", {30'd0, HTRANS}, 32'd2);
    @(posedge clk); #1;
    check("rmid_wait1", {30'd0, HTRANS}, 32'd2);
    @(posedge clk); #1;
    check("rmid_wait2", {30'd0, HTRANS}, 32'd2);
    #1 reset = 1'b1;
    #1;
    check("rmid_htrans_idle", {30'd0, HTRANS}, 32'd0);
    check("rmid_done", {31'd0, done}, 32'd0);
    check("rmid_reg_write", {31'd0, reg_write}, 32'd0);
    @(negedge clk); reset = 1'b0; HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rmid_post_done", {31'd0, done}, 32'd0);
      check("rmid_post_reg_write", {31'd0, reg_write}, 32'd0);
      check("rmid_post_htrans", {30'd0, HTRANS}, 32'd0);
      check("rmid_post_ready", {31'd0, req_ready}, 32'd1);
    end

    // A normal transfer still works after the abandoned one.
    run_req(1'b0, 3'b001, 32'h0000_0312, 32'h0, 5'd12, 32'h7FFF_0001, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
